// File: rtl/core_quant_packer.sv
// Packs MAC_MULT_NUM quantized results per bus word and writes each word to the
// output global bus at consecutive addresses, pulsing done after the job's last result.
module core_quant_packer #(
  parameter int MAC_MULT_NUM    = 8,
  parameter int IDATA_WIDTH     = 8,
  parameter int GBUS_DATA_WIDTH = 64,
  parameter int GBUS_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_vld,
  input  logic [GBUS_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]       cfg_out_len,
  input  logic [IDATA_WIDTH-1:0]     quant_odata,
  input  logic                       quant_odata_valid,
  output logic [GBUS_ADDR_WIDTH-1:0] out_gbus_addr,
  output logic                       out_gbus_wen,
  output logic [GBUS_DATA_WIDTH-1:0] out_gbus_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow_err
);

  localparam int LANE_W = (MAC_MULT_NUM > 1) ? $clog2(MAC_MULT_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACK = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [GBUS_ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [LEN_WIDTH-1:0]       r_res_cnt;
  logic [GBUS_ADDR_WIDTH-1:0] r_word_idx;
  logic [LANE_W-1:0]          r_lane_idx;
  logic [GBUS_DATA_WIDTH-1:0] r_lanes;
  logic [GBUS_ADDR_WIDTH-1:0] r_addr;
  logic [GBUS_DATA_WIDTH-1:0] r_wdata;
  logic                       r_wen;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_ovf;

  logic                       w_start;
  logic                       w_store;
  logic                       w_last;
  logic                       w_full;
  logic                       w_flush;
  logic                       w_drop;
  logic [LEN_WIDTH-1:0]       w_res_nxt;
  logic [GBUS_DATA_WIDTH-1:0] w_word;

  assign w_res_nxt = r_res_cnt + LEN_WIDTH'(1);
  assign w_store   = (r_state == S_PACK) && quant_odata_valid;
  assign w_last    = w_store && (w_res_nxt == r_len);
  assign w_full    = w_store && (r_lane_idx == LANE_W'(MAC_MULT_NUM - 1));
  assign w_flush   = w_last || w_full;
  assign w_drop    = quant_odata_valid && (r_state != S_PACK);

  // Current lane image with the incoming result merged into lane r_lane_idx
  always_comb begin
    w_word = r_lanes;
    for (int k = 0; k < MAC_MULT_NUM; k++) begin
      if (r_lane_idx == LANE_W'(k)) begin
        w_word[k*IDATA_WIDTH +: IDATA_WIDTH] = quant_odata;
      end else begin
        w_word[k*IDATA_WIDTH +: IDATA_WIDTH] = r_lanes[k*IDATA_WIDTH +: IDATA_WIDTH];
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_vld && (cfg_out_len != LEN_WIDTH'(0))) begin
          w_state_nxt = S_PACK;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PACK: begin
        if (w_last) begin
          w_state_nxt = S_LAST;
        end else begin
          w_state_nxt = S_PACK;
        end
      end
      S_LAST:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job context, lane packing and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= {GBUS_ADDR_WIDTH{1'b0}};
      r_len      <= {LEN_WIDTH{1'b0}};
      r_res_cnt  <= {LEN_WIDTH{1'b0}};
      r_word_idx <= {GBUS_ADDR_WIDTH{1'b0}};
      r_lane_idx <= {LANE_W{1'b0}};
      r_lanes    <= {GBUS_DATA_WIDTH{1'b0}};
      r_addr     <= {GBUS_ADDR_WIDTH{1'b0}};
      r_wdata    <= {GBUS_DATA_WIDTH{1'b0}};
      r_wen      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_wen  <= w_flush;
      r_done <= (r_state == S_LAST);
      r_ovf  <= r_ovf | w_drop;
      if (r_state == S_LAST) begin
        r_busy <= 1'b0;
      end else if (w_start) begin
        r_busy <= 1'b1;
      end
      if (w_start) begin
        r_res_cnt <= {LEN_WIDTH{1'b0}};
      end else if (w_store) begin
        r_res_cnt <= w_res_nxt;
      end
      if (w_start) begin
        r_base     <= cfg_base_addr;
        r_len      <= cfg_out_len;
        r_word_idx <= {GBUS_ADDR_WIDTH{1'b0}};
        r_lane_idx <= {LANE_W{1'b0}};
        r_lanes    <= {GBUS_DATA_WIDTH{1'b0}};
      end else if (w_flush) begin
        // Clearing the lanes here zero-fills any partial final word
        r_wdata    <= w_word;
        r_addr     <= r_base + r_word_idx;
        r_word_idx <= r_word_idx + GBUS_ADDR_WIDTH'(1);
        r_lane_idx <= {LANE_W{1'b0}};
        r_lanes    <= {GBUS_DATA_WIDTH{1'b0}};
      end else if (w_store) begin
        r_lanes    <= w_word;
        r_lane_idx <= r_lane_idx + LANE_W'(1);
      end
    end
  end

  assign out_gbus_addr  = r_addr;
  assign out_gbus_wen   = r_wen;
  assign out_gbus_wdata = r_wdata;
  assign busy           = r_busy;
  assign done           = r_done;
  assign overflow_err   = r_ovf;

endmodule

// File: tb/tb_core_quant_packer.sv
// Self-checking bench for core_quant_packer: table-driven jobs, random jobs against a
// word-level reference model, and hand-written illegal-input and abort sequences.
module tb_core_quant_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_vld;
  logic [15:0] cfg_base_addr;
  logic [15:0] cfg_out_len;
  logic [7:0]  quant_odata;
  logic        quant_odata_valid;
  logic [15:0] out_gbus_addr;
  logic        out_gbus_wen;
  logic [63:0] out_gbus_wdata;
  logic        busy;
  logic        done;
  logic        overflow_err;

  core_quant_packer dut (
    .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_base_addr(cfg_base_addr),
    .cfg_out_len(cfg_out_len), .quant_odata(quant_odata), .quant_odata_valid(quant_odata_valid),
    .out_gbus_addr(out_gbus_addr), .out_gbus_wen(out_gbus_wen), .out_gbus_wdata(out_gbus_wdata),
    .busy(busy), .done(done), .overflow_err(overflow_err)
  );

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
    int          c;
  } wr_t;

  typedef struct {
    logic [15:0] base;
    int          len;
    int          gap;
    int          exp_nw;
    logic [15:0] exp_last_addr;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          done_seen;
  int          done_cyc;
  wr_t         obs_q[$];
  logic [7:0]  din[$];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write/done monitor, sampling on the falling edge
  initial forever begin
    @(negedge clk);
    if (out_gbus_wen) obs_q.push_back('{out_gbus_addr, out_gbus_wdata, cyc});
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one job from din[] and compare every write and the done pulse against the model
  task automatic run_job(input logic [15:0] base, input int len, input int gap, input bit rnd,
                         input bit midcfg, input bit extra);
    int          vcyc[$];
    wr_t         exp_q[$];
    logic [63:0] w;
    int          g;
    int          t;
    obs_q.delete();
    done_seen = 1'b0;
    @(negedge clk);
    cfg_vld = 1'b1; cfg_base_addr = base; cfg_out_len = 16'(len);
    @(negedge clk);
    cfg_vld = 1'b0;
    for (int i = 0; i < len; i++) begin
      g = rnd ? int'($urandom_range(0, gap)) : gap;
      repeat (g) @(negedge clk);
      if (i == 0) chk("busy_in_job", {63'd0, busy}, 64'd1);
      if (midcfg && i == 2) begin
        cfg_vld = 1'b1; cfg_base_addr = base ^ 16'h5555; cfg_out_len = 16'd5;
      end
      quant_odata = din[i]; quant_odata_valid = 1'b1;
      vcyc.push_back(cyc + 1);
      @(negedge clk);
      quant_odata_valid = 1'b0; cfg_vld = 1'b0;
    end
    if (extra) begin
      quant_odata = 8'h5A; quant_odata_valid = 1'b1;
      @(negedge clk);
      quant_odata_valid = 1'b0;
    end
    t = 0;
    while (!done_seen && t < 10) begin
      @(negedge clk);
      t++;
    end
    w = 64'd0;
    for (int i = 0; i < len; i++) begin
      w[8*(i%8) +: 8] = din[i];
      if ((i % 8) == 7 || i == len - 1) begin
        exp_q.push_back('{16'(base + 16'(i / 8)), w, vcyc[i]});
        w = 64'd0;
      end
    end
    chk("num_writes", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      chk("wr_addr", {48'd0, obs_q[k].a}, {48'd0, exp_q[k].a});
      chk("wr_data", obs_q[k].d, exp_q[k].d);
      chk("wr_cycle", 64'(obs_q[k].c), 64'(exp_q[k].c));
    end
    chk("done_seen", {63'd0, done_seen}, 64'd1);
    chk("done_cycle", 64'(done_cyc), 64'(exp_q[$].c + 1));
    @(negedge clk);
    chk("busy_after", {63'd0, busy}, 64'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h0100, 16, 0, 2, 16'h0101, 64'h0807060504030201, 64'h100F0E0D0C0B0A09};
    vecs[1] = '{16'hFFFF, 16, 0, 2, 16'h0000, 64'h0807060504030201, 64'h100F0E0D0C0B0A09};
    vecs[2] = '{16'h0200,  8, 2, 1, 16'h0200, 64'h0807060504030201, 64'h0807060504030201};
    vecs[3] = '{16'h0010,  3, 1, 1, 16'h0010, 64'h0000000000030201, 64'h0000000000030201};
    vecs[4] = '{16'h0020,  9, 0, 2, 16'h0021, 64'h0807060504030201, 64'h0000000000000009};

    rst = 1'b1; cfg_vld = 1'b0; cfg_base_addr = 16'd0; cfg_out_len = 16'd0;
    quant_odata = 8'd0; quant_odata_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wen",   {63'd0, out_gbus_wen}, 64'd0);
    chk("rst_addr",  {48'd0, out_gbus_addr}, 64'd0);
    chk("rst_wdata", out_gbus_wdata, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_ovf",   {63'd0, overflow_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      din.delete();
      for (int i = 0; i < vecs[v].len; i++) din.push_back(8'(i + 1));
      run_job(vecs[v].base, vecs[v].len, vecs[v].gap, 1'b0, 1'b0, 1'b0);
      chk("tbl_nw", 64'(obs_q.size()), 64'(vecs[v].exp_nw));
      if (obs_q.size() > 0) begin
        chk("tbl_first", obs_q[0].d, vecs[v].exp_first);
        chk("tbl_last", obs_q[$].d, vecs[v].exp_last);
        chk("tbl_last_addr", {48'd0, obs_q[$].a}, {48'd0, vecs[v].exp_last_addr});
      end
    end

    din.delete();
    din.push_back(8'hFF); din.push_back(8'h7F); din.push_back(8'h80);
    run_job(16'h0040, 3, 2, 1'b0, 1'b0, 1'b0);
    if (obs_q.size() > 0) chk("partial_word", obs_q[0].d, 64'h0000000000807FFF);

    for (int r = 0; r < 20; r++) begin
      int len;
      len = int'($urandom_range(1, 40));
      din.delete();
      for (int i = 0; i < len; i++) din.push_back(8'($urandom_range(0, 255)));
      run_job(16'($urandom), len, 3, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf_clean", {63'd0, overflow_err}, 64'd0);

    din.delete();
    for (int i = 0; i < 12; i++) din.push_back(8'($urandom_range(0, 255)));
    run_job(16'h1230, 12, 1, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    cfg_vld = 1'b1; cfg_base_addr = 16'h0777; cfg_out_len = 16'd0;
    @(negedge clk);
    cfg_vld = 1'b0;
    chk("len0_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("len0_busy2", {63'd0, busy}, 64'd0);

    obs_q.delete();
    quant_odata = 8'hAA; quant_odata_valid = 1'b1;
    @(negedge clk);
    quant_odata_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_valid_nowrite", 64'(obs_q.size()), 64'd0);
    chk("idle_valid_ovf", {63'd0, overflow_err}, 64'd1);

    reset_dut();
    chk("ovf_cleared", {63'd0, overflow_err}, 64'd0);
    din.delete();
    din.push_back(8'h11); din.push_back(8'h22);
    run_job(16'h0300, 2, 0, 1'b0, 1'b0, 1'b1);
    chk("last_valid_ovf", {63'd0, overflow_err}, 64'd1);

    @(negedge clk);
    cfg_vld = 1'b1; cfg_base_addr = 16'h0500; cfg_out_len = 16'd8;
    @(negedge clk);
    cfg_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      quant_odata = 8'(8'hC0 + i); quant_odata_valid = 1'b1;
      @(negedge clk);
      quant_odata_valid = 1'b0;
    end
    obs_q.delete();
    done_seen = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_wen",   {63'd0, out_gbus_wen}, 64'd0);
    chk("abort_busy",  {63'd0, busy}, 64'd0);
    chk("abort_done",  {63'd0, done}, 64'd0);
    chk("abort_ovf",   {63'd0, overflow_err}, 64'd0);
    chk("abort_addr",  {48'd0, out_gbus_addr}, 64'd0);
    chk("abort_wdata", out_gbus_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_nowrite", 64'(obs_q.size()), 64'd0);
    chk("abort_nodone", {63'd0, done_seen}, 64'd0);
    din.delete();
    for (int i = 0; i < 8; i++) din.push_back(8'(8'h31 + i));
    run_job(16'h0400, 8, 0, 1'b0, 1'b0, 1'b0);
    if (obs_q.size() > 0) chk("post_abort_word", obs_q[0].d, 64'h3837363534333231);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
